// File: rtl/alu_ft_issue.sv
// alu_ft_issue: issue stage in front of the time-redundant fault-tolerant ALU.
// Queues operations in a small FIFO. Each popped operation is held stable on
// alu_a/alu_b/alu_ctrl for HOLD_CYCLES cycles, long enough for the ALU's worst-case
// compute/compare/recover sequence. The ALU's registered result and flags are then
// captured and returned over a valid/ready result channel.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   in_valid/in_ready            operation request handshake
//   in_a, in_b, in_ctrl          operands and 3-bit ALU control
//   alu_a, alu_b, alu_ctrl       operation currently held at the ALU
//   alu_result, alu_flags        ALU registered Result and {Zero, Carry, OverFlow, Negative}
//   res_valid/res_ready          result handshake
//   res_data, res_flags          captured result and flags
//   busy                         an operation is in flight or queued
`timescale 1ns/1ps
module alu_ft_issue #(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [2:0]  in_ctrl,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    input  logic [3:0]  alu_flags,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [3:0]  res_flags,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = 4;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  ctrl;
    } op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOLD     = 2'd1,
        CAPTURE  = 2'd2,
        WAIT_OUT = 2'd3
    } state_e;

    op_t           mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW-1:0] wr_ptr_d, rd_ptr_d;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    op_t           issue_q;
    logic          res_valid_q;
    logic [31:0]   res_data_q;
    logic [3:0]    res_flags_q;

    logic empty_c, full_c, push_c, pop_c;
    op_t  head_c;

    // FIFO status: the extra pointer MSB separates full from empty
    always_comb begin
        empty_c = (wr_ptr_q == rd_ptr_q);
        full_c  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        push_c  = in_valid && !full_c;
        // Pops happen only when the ALU port is free: idle, or the pending result is taken
        pop_c   = !empty_c && ((state_q == IDLE) || ((state_q == WAIT_OUT) && res_ready));
        head_c  = mem_q[rd_ptr_q[AW-1:0]];
        wr_ptr_d = push_c ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_c  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    end

    // FIFO storage (data only, no reset needed)
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{a: in_a, b: in_b, ctrl: in_ctrl};
        end
    end

    // Pointers, issue FSM and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            issue_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flags_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            case (state_q)
                IDLE: begin
                    if (pop_c) begin
                        issue_q <= head_c;
                        cnt_q   <= CW'(HOLD_CYCLES - 1);
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (cnt_q == '0) begin
                        state_q <= CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                CAPTURE: begin
                    res_data_q  <= alu_result;
                    res_flags_q <= alu_flags;
                    res_valid_q <= 1'b1;
                    state_q     <= WAIT_OUT;
                end
                WAIT_OUT: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (pop_c) begin
                            issue_q <= head_c;
                            cnt_q   <= CW'(HOLD_CYCLES - 1);
                            state_q <= HOLD;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = !full_c;
    assign busy      = (state_q != IDLE) || !empty_c;
    assign alu_a     = issue_q.a;
    assign alu_b     = issue_q.b;
    assign alu_ctrl  = issue_q.ctrl;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_flags = res_flags_q;

endmodule

// File: tb/tb_alu_ft_issue.sv
// Testbench for alu_ft_issue with a two-stage registered ALU stand-in and a
// result scoreboard fed at request acceptance.
`timescale 1ns/1ps
module tb_alu_ft_issue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned HOLD  = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic [2:0]  in_ctrl = '0;
    logic [31:0] alu_a, alu_b;
    logic [2:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic [3:0]  res_flags;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_ft_issue #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_ctrl(in_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_flags(alu_flags),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_flags(res_flags),
        .busy(busy)
    );

    // Reference ALU: {result, Zero, Carry, OverFlow, Negative}
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        logic [32:0] s;
        logic [31:0] r;
        logic        cy, v;
        s = '0; r = '0; cy = 1'b0; v = 1'b0;
        case (c)
            3'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; cy = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'd1: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; cy = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: r = a ^ b;
            default: r = a;
        endcase
        return {r, (r == 32'd0), cy, v, r[31]};
    endfunction

    // ALU stand-in with two register stages of latency
    logic [35:0] p1 = '0, p2 = '0;
    always @(posedge clk) begin
        p1 <= alu_model(alu_a, alu_b, alu_ctrl);
        p2 <= p1;
    end
    assign alu_result = p2[35:4];
    assign alu_flags  = p2[3:0];

    // Scoreboard: expected pushed at request acceptance, compared at result acceptance
    logic [35:0] sb[$];
    logic [35:0] sb_exp;
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (res_valid && res_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_unexpected: got data=%h flags=%b, required no result", res_data, res_flags);
                end else begin
                    sb_exp = sb.pop_front();
                    if ({res_data, res_flags} !== sb_exp) begin
                        n_bad++;
                        $display("FAIL sb_order: got data=%h flags=%b, required data=%h flags=%b",
                                 res_data, res_flags, sb_exp[35:4], sb_exp[3:0]);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back(alu_model(in_a, in_b, in_ctrl));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded)
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        bit ok;
        ok = 1'b0;
        in_a = a; in_b = b; in_ctrl = c; in_valid = 1'b1;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        if (!ok) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: got in_ready=0 for 60 cycles, required acceptance");
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && busy; i++) tick();
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL idle_timeout: got busy=%b, required 0", busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b, required 1", in_ready); end
        n_cmp++;
        if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b, required 0", busy); end
        n_cmp++;
        if (res_valid !== 1'b0) begin n_bad++; $display("FAIL rst_res_valid: got %b, required 0", res_valid); end
        n_cmp++;
        if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin
            n_bad++; $display("FAIL rst_alu: got %h/%h/%b, required 0/0/000", alu_a, alu_b, alu_ctrl);
        end
        n_cmp++;
        if ({res_data, res_flags} !== 36'd0) begin
            n_bad++; $display("FAIL rst_res: got %h/%b, required 0/0000", res_data, res_flags);
        end
    endtask

    task automatic test_single_op();
        int  rise;
        bit  moved;
        rise = 0; moved = 1'b0;
        res_ready = 1'b0;
        send(32'd5, 32'd3, 3'b000);
        tick();
        n_cmp++;
        if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd3, 3'b000}) begin
            n_bad++; $display("FAIL add_issue: got %h/%h/%b, required 5/3/000", alu_a, alu_b, alu_ctrl);
        end
        for (int k = 1; k <= 12 && rise == 0; k++) begin
            tick();
            if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd3, 3'b000}) moved = 1'b1;
            if (res_valid) rise = k;
        end
        n_cmp++;
        if (rise != HOLD + 1) begin n_bad++; $display("FAIL add_latency: got %0d, required %0d", rise, HOLD + 1); end
        n_cmp++;
        if (moved) begin n_bad++; $display("FAIL add_alu_stable: got change before result, required stable"); end
        n_cmp++;
        if ({res_data, res_flags} !== {32'd8, 4'b0000}) begin
            n_bad++; $display("FAIL add_result: got %h/%b, required 8/0000", res_data, res_flags);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        n_cmp++;
        if (res_valid !== 1'b0) begin n_bad++; $display("FAIL add_release: got res_valid=%b, required 0", res_valid); end
    endtask

    task automatic test_sub_zero();
        wait_idle();
        res_ready = 1'b0;
        send(32'd7, 32'd7, 3'b001);
        for (int k = 0; k < 12 && !res_valid; k++) tick();
        n_cmp++;
        if (res_data !== 32'd0 || res_flags[3] !== 1'b1) begin
            n_bad++; $display("FAIL sub_zero: got data=%h flags=%b, required data=0 Zero=1", res_data, res_flags);
        end
        n_cmp++;
        if (res_flags !== 4'b1100) begin
            n_bad++; $display("FAIL sub_flags: got %b, required 1100", res_flags);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_fill_backpressure();
        int          accepted;
        bit          acc;
        logic [31:0] first_a;
        wait_idle();
        res_ready = 1'b0;
        accepted = 0;
        in_a = $urandom; in_b = $urandom; in_ctrl = 3'($urandom_range(0, 4));
        first_a = in_a;
        in_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) begin
                accepted++;
                in_a = $urandom; in_b = $urandom; in_ctrl = 3'($urandom_range(0, 4));
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (accepted != DEPTH + 1) begin n_bad++; $display("FAIL fill_accepted: got %0d, required %0d", accepted, DEPTH + 1); end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_in_ready: got %b, required 0", in_ready); end
        n_cmp++;
        if (res_valid !== 1'b1 || alu_a !== first_a) begin
            n_bad++; $display("FAIL fill_pending: got res_valid=%b alu_a=%h, required 1/%h", res_valid, alu_a, first_a);
        end
        res_ready = 1'b1;
        wait_idle();
        n_cmp++;
        if (sb.size() != 0) begin n_bad++; $display("FAIL fill_drain: got %0d outstanding, required 0", sb.size()); end
        res_ready = 1'b0;
    endtask

    task automatic test_stability();
        logic [66:0] op;
        int          bad;
        bad = 0;
        wait_idle();
        res_ready = 1'b0;
        op = {32'($urandom), 32'($urandom), 3'($urandom_range(0, 4))};
        send(op[66:35], op[34:3], op[2:0]);
        tick();
        for (int k = 0; k < HOLD + 1; k++) begin
            in_a = $urandom; in_b = $urandom; in_ctrl = 3'($urandom);
            tick();
            if ({alu_a, alu_b, alu_ctrl} !== op) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL stability: got %0d changed cycles, required 0", bad); end
        n_cmp++;
        if (res_valid !== 1'b1) begin n_bad++; $display("FAIL stability_result: got res_valid=%b, required 1", res_valid); end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        bit seen;
        seen = 1'b0;
        wait_idle();
        res_ready = 1'b0;
        for (int i = 0; i < 4; i++) send($urandom, $urandom, 3'($urandom_range(0, 4)));
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if ({res_valid, busy, in_ready} !== 3'b001) begin
            n_bad++; $display("FAIL rst_mid_ctrl: got valid/busy/ready=%b%b%b, required 001", res_valid, busy, in_ready);
        end
        n_cmp++;
        if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin
            n_bad++; $display("FAIL rst_mid_alu: got %h/%h/%b, required 0/0/000", alu_a, alu_b, alu_ctrl);
        end
        res_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (res_valid) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin n_bad++; $display("FAIL rst_mid_stale: got res_valid=1 after reset, required none"); end
        res_ready = 1'b0;
    endtask

    task automatic test_streaming();
        int t[8];
        int n, bad_gap;
        bit busy_last;
        n = 0; bad_gap = 0; busy_last = 1'b0;
        wait_idle();
        res_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) send($urandom, $urandom, 3'($urandom_range(0, 4)));
            end
            begin
                for (int c = 0; c < 300 && n < 8; c++) begin
                    @(negedge clk);
                    if (res_valid && res_ready) begin
                        t[n] = cyc;
                        n++;
                        busy_last = busy;
                    end
                end
            end
        join
        tick();
        n_cmp++;
        if (n != 8) begin n_bad++; $display("FAIL stream_count: got %0d, required 8", n); end
        for (int i = 1; i < 8; i++) if (i < n && t[i] - t[i-1] != HOLD + 2) bad_gap++;
        n_cmp++;
        if (bad_gap != 0) begin n_bad++; $display("FAIL stream_spacing: got %0d wrong gaps, required 0 (gap %0d)", bad_gap, HOLD + 2); end
        n_cmp++;
        if ({busy_last, busy} !== 2'b10) begin
            n_bad++; $display("FAIL stream_busy: got at/after last=%b/%b, required 1/0", busy_last, busy);
        end
        res_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_sub_zero();
        test_fill_backpressure();
        test_stability();
        test_reset_mid_hold();
        test_streaming();
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by 200000ns, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_ft_issue.md
Name: alu_ft_issue

Overview:
- Upstream issue stage for the time-redundant fault-tolerant ALU.
- Buffers incoming ALU operations in a small FIFO and drives A/B/ALUControl to the ALU.
- Holds each operation stable for a fixed window that covers the ALU's worst-case compute/recompute/recover sequence in any FSM phase.
- Then captures the ALU's registered Result/flags and returns them to the requester over a valid/ready result channel.

Parameters:
- DEPTH, 4: operation FIFO entries; power of 2, >= 2.
- HOLD_CYCLES, 4: cycles each operation is driven to the ALU before capture; legal range 4..15.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  operation request valid
- in_ready  output  1  FIFO can accept an operation
- in_a  input  32  operand A
- in_b  input  32  operand B
- in_ctrl  input  3  ALU control code
- alu_a  output  32  operand A to ALU
- alu_b  output  32  operand B to ALU
- alu_ctrl  output  3  control to ALU
- alu_result  input  32  ALU registered Result
- alu_flags  input  4  {Zero, Carry, OverFlow, Negative} from ALU
- res_valid  output  1  captured result valid
- res_ready  input  1  consumer accepts result
- res_data  output  32  captured result
- res_flags  output  4  captured flags, same bit order as alu_flags
- busy  output  1  high when any operation is in flight or queued

Behaviour:
- Reset, sampled on the clk rising edge while rst=1, clears the FIFO and returns the FSM to IDLE.
- Reset values: in_ready=1, alu_a=0, alu_b=0, alu_ctrl=0, res_valid=0, res_data=0, res_flags=0, busy=0.
- Reset mid-operation drops all queued and in-flight operations; no res_valid pulse follows.
- FIFO write: in_valid && in_ready. in_ready = !full.
- Simultaneous push and pop when full: not allowed; in_ready=0 blocks the push.
- Simultaneous push and pop when empty: not allowed, because the pop needs an entry present in the prior cycle.
- Pointers are log2(DEPTH)+1 bits. The MSB distinguishes full from empty; pointers wrap modulo 2*DEPTH.
- FSM states:
  - IDLE: if FIFO non-empty, pop the head into the alu_a/alu_b/alu_ctrl registers, load hold counter = HOLD_CYCLES-1, go to HOLD.
  - HOLD: alu_* outputs stay constant. Counter decrements each cycle; at 0 go to CAPTURE.
  - CAPTURE: register alu_result and alu_flags into res_data and res_flags, set res_valid=1, go to WAIT_OUT.
  - WAIT_OUT: hold res_* stable while res_valid && !res_ready. On res_ready, clear res_valid, then go to IDLE, or pop the next entry directly into HOLD if the FIFO is non-empty.
- alu_* outputs keep the last operation's values in IDLE and WAIT_OUT. They change only on a pop.
- Latency: an operation pushed into an empty FIFO while idle is popped the next cycle. alu_* update at the end of that cycle. res_valid rises HOLD_CYCLES+1 cycles after the alu_* update edge.
- HOLD_CYCLES=4 rationale: worst phase is the ALU entering its compare stage on the first cycle with new operands. That phase costs one mismatch, then recovery, then a clean compute/compare pass. The result register is settled after 4 cycles of stable operands.
- Minimum operation spacing: HOLD_CYCLES+2 cycles, with res_ready held high.
- Back-pressure: while res_valid=1 and res_ready=0, no new operation is issued to the ALU. The FIFO still accepts pushes until full.
- busy = (state != IDLE) || FIFO non-empty.
- No arithmetic in this block. Data passes through unmodified at full width.

Test Plan:
- Single op: push A=5, B=3, ctrl=000 (add) -> alu_a/alu_b/alu_ctrl = 5/3/000 for exactly HOLD_CYCLES+2 cycles before any change. res_valid rises 5 cycles after alu_* update. res_data=8, res_flags=0000.
- Subtract to zero: push A=7, B=7, ctrl=001 -> res_data=0, Zero flag=1 (res_flags[3]=1). Flags must match ALU outputs at capture.
- Fill and back-pressure: push 6 ops back-to-back with res_ready=0 -> in_ready drops after 4 accepted plus 1 in flight. Exactly one res_valid is pending. Release res_ready and results emerge in push order with no loss or duplication.
- Operand stability: drive in_* with random values every cycle during HOLD -> alu_* never change until the next pop.
- Reset mid-HOLD: assert rst for 1 cycle while 3 ops are queued -> next cycle res_valid=0, busy=0, in_ready=1, all alu_*=0. No stale result appears afterward.
- Streaming with res_ready=1: 8 ops -> one result every HOLD_CYCLES+2 cycles, results in order, busy deasserts the cycle after the last result is accepted.
